// File: rtl/scr1_mem_req_arb.sv
// Two-requester round-robin arbiter in front of a single SCR1 memory bridge port.
// An in-order owner-ID FIFO steers each bridge response back to the requester
// that issued the corresponding accepted request.
module scr1_mem_req_arb #(
  parameter int unsigned SCR1_ARB_OUTSTD = 4,
  parameter int unsigned SCR1_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  // requester 0
  input  logic                       p0_req,
  output logic                       p0_req_ack,
  input  logic                       p0_cmd,
  input  logic [1:0]                 p0_width,
  input  logic [SCR1_ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]                p0_wdata,
  output logic [31:0]                p0_rdata,
  output logic [1:0]                 p0_resp,
  // requester 1
  input  logic                       p1_req,
  output logic                       p1_req_ack,
  input  logic                       p1_cmd,
  input  logic [1:0]                 p1_width,
  input  logic [SCR1_ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]                p1_wdata,
  output logic [31:0]                p1_rdata,
  output logic [1:0]                 p1_resp,
  // bridge side
  output logic                       m_req,
  input  logic                       m_req_ack,
  output logic                       m_cmd,
  output logic [1:0]                 m_width,
  output logic [SCR1_ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]                m_wdata,
  input  logic [31:0]                m_rdata,
  input  logic [1:0]                 m_resp,
  // status
  output logic                       arb_idle,
  output logic                       err_unexp
);

  localparam int unsigned PW = $clog2(SCR1_ARB_OUTSTD);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    RESP_NOTRDY = 2'b00,
    RESP_OK     = 2'b01,
    RESP_ER     = 2'b10
  } resp_e;

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SCR1_ARB_OUTSTD-1:0] owner_q, owner_d;
  logic                       lock_q, lock_d;
  logic                       lock_id_q, lock_id_d;
  logic                       rr_last_q, rr_last_d;
  logic                       err_q, err_d;

  logic                       grant;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       resp_vld;
  logic                       owner;
  logic [1:0]                 resp_fwd;

  // Grant selection and muxed request toward the bridge
  always_comb begin
    full = (cnt_q == CW'(SCR1_ARB_OUTSTD));
    if (lock_q) begin
      grant = lock_id_q;
    end else if (p0_req && p1_req) begin
      grant = ~rr_last_q;
    end else begin
      grant = p1_req;
    end
    m_req      = (p0_req | p1_req) & ~full;
    push       = m_req & m_req_ack;
    p0_req_ack = push & ~grant;
    p1_req_ack = push & grant;
    m_cmd      = 1'b0;
    m_width    = '0;
    m_addr     = '0;
    m_wdata    = '0;
    if (m_req) begin
      m_cmd   = grant ? p1_cmd   : p0_cmd;
      m_width = grant ? p1_width : p0_width;
      m_addr  = grant ? p1_addr  : p0_addr;
      m_wdata = grant ? p1_wdata : p0_wdata;
    end
  end

  // Response steering to the owner at the FIFO head; 2'b11 is forwarded as an error
  always_comb begin
    resp_vld = (m_resp != RESP_NOTRDY);
    pop      = resp_vld & (cnt_q != '0);
    owner    = owner_q[rd_ptr_q];
    resp_fwd = (m_resp == 2'b11) ? RESP_ER : m_resp;
    p0_resp  = RESP_NOTRDY;
    p1_resp  = RESP_NOTRDY;
    p0_rdata = '0;
    p1_rdata = '0;
    if (pop) begin
      if (owner) begin
        p1_resp  = resp_fwd;
        p1_rdata = m_rdata;
      end else begin
        p0_resp  = resp_fwd;
        p0_rdata = m_rdata;
      end
    end
    arb_idle  = (cnt_q == '0) & ~lock_q;
    err_unexp = err_q;
  end

  // Next-state: grant lock, round-robin history, owner FIFO and error flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_last_d = rr_last_q;
    err_d     = err_q;
    if (m_req) begin
      if (m_req_ack) begin
        lock_d            = 1'b0;
        rr_last_d         = grant;
        owner_d[wr_ptr_q] = grant;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end else begin
        lock_d    = 1'b1;
        lock_id_d = grant;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (resp_vld && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous reset; rr_last=1 lets port 0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      rr_last_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_scr1_mem_req_arb.sv
// Directed self-checking bench for scr1_mem_req_arb (OUTSTD=4, AW=32).
module tb_scr1_mem_req_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_req_ack, p0_cmd;
  logic [1:0]  p0_width, p0_resp;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_req_ack, p1_cmd;
  logic [1:0]  p1_width, p1_resp;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        m_req, m_req_ack, m_cmd;
  logic [1:0]  m_width, m_resp;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        arb_idle, err_unexp;

  int unsigned tests = 0;
  int unsigned fails = 0;

  scr1_mem_req_arb #(.SCR1_ARB_OUTSTD(4), .SCR1_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_req_ack(p0_req_ack), .p0_cmd(p0_cmd), .p0_width(p0_width),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_resp(p0_resp),
    .p1_req(p1_req), .p1_req_ack(p1_req_ack), .p1_cmd(p1_cmd), .p1_width(p1_width),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_resp(p1_resp),
    .m_req(m_req), .m_req_ack(m_req_ack), .m_cmd(m_cmd), .m_width(m_width),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp),
    .arb_idle(arb_idle), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs;
    p0_req = 0; p0_cmd = 0; p0_width = 2'b10; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_cmd = 0; p1_width = 2'b10; p1_addr = '0; p1_wdata = '0;
    m_req_ack = 0; m_rdata = '0; m_resp = 2'b00;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    // Cleared state while reset is still asserted
    chk("rst_m_req", m_req, 0);
    chk("rst_idle", arb_idle, 1);
    chk("rst_err", err_unexp, 0);
    chk("rst_p0_resp", p0_resp, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    rst = 0;

    // Single p0 read, zero-latency ack, response next cycle
    p0_req = 1; p0_addr = 32'h100; m_req_ack = 1;
    #1;
    chk("t1_m_req", m_req, 1);
    chk("t1_p0_ack", p0_req_ack, 1);
    chk("t1_p1_ack", p1_req_ack, 0);
    chk("t1_m_addr", m_addr, 32'h100);
    tick();
    p0_req = 0; m_req_ack = 0; m_resp = 2'b01; m_rdata = 32'hDEAD0001;
    #1;
    chk("t1_p0_resp", p0_resp, 2'b01);
    chk("t1_p0_rdata", p0_rdata, 32'hDEAD0001);
    chk("t1_p1_resp", p1_resp, 2'b00);
    chk("t1_p1_rdata", p1_rdata, 0);
    tick();
    m_resp = 2'b00;
    #1;
    chk("t1_idle", arb_idle, 1);

    // Round robin from reset: 0,1,0,1 grants and in-order response routing
    do_reset();
    p0_req = 1; p0_addr = 32'h200; p1_req = 1; p1_addr = 32'h300; m_req_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_p0_ack", p0_req_ack, (i % 2) == 0);
      chk("t2_p1_ack", p1_req_ack, (i % 2) == 1);
      chk("t2_m_addr", m_addr, ((i % 2) == 0) ? 32'h200 : 32'h300);
      tick();
    end
    p0_req = 0; p1_req = 0; m_req_ack = 0;
    for (int i = 0; i < 4; i++) begin
      m_resp = 2'b01; m_rdata = 32'hA0 + i;
      #1;
      chk("t2_p0_resp", p0_resp, ((i % 2) == 0) ? 2'b01 : 2'b00);
      chk("t2_p1_resp", p1_resp, ((i % 2) == 1) ? 2'b01 : 2'b00);
      chk("t2_rdata", ((i % 2) == 0) ? p0_rdata : p1_rdata, 32'hA0 + i);
      tick();
    end
    m_resp = 2'b00;
    #1;
    chk("t2_idle", arb_idle, 1);

    // Locked grant: p1 write stalled 3 cycles, p0 joins but must wait
    p1_req = 1; p1_cmd = 1; p1_addr = 32'h400; p1_wdata = 32'h55AA;
    #1;
    chk("t3_c0_addr", m_addr, 32'h400);
    chk("t3_c0_cmd", m_cmd, 1);
    chk("t3_c0_ack", p1_req_ack, 0);
    chk("t3_c0_idle", arb_idle, 1);
    tick();
    p0_req = 1; p0_addr = 32'h500;
    #1;
    chk("t3_c1_addr", m_addr, 32'h400);
    chk("t3_c1_wdata", m_wdata, 32'h55AA);
    chk("t3_c1_idle", arb_idle, 0);
    tick();
    #1;
    chk("t3_c2_addr", m_addr, 32'h400);
    tick();
    m_req_ack = 1;
    #1;
    chk("t3_p1_ack", p1_req_ack, 1);
    chk("t3_p0_noack", p0_req_ack, 0);
    tick();
    p1_req = 0; p1_cmd = 0;
    #1;
    chk("t3_p0_ack", p0_req_ack, 1);
    chk("t3_p0_addr", m_addr, 32'h500);
    tick();
    p0_req = 0; m_req_ack = 0;
    m_resp = 2'b01; m_rdata = 32'h11;
    #1;
    chk("t3_r0_p1", p1_resp, 2'b01);
    chk("t3_r0_p0", p0_resp, 2'b00);
    tick();
    m_resp = 2'b11; m_rdata = 32'h22;
    #1;
    chk("t3_r1_p0_11", p0_resp, 2'b10);
    chk("t3_r1_p1", p1_resp, 2'b00);
    tick();
    m_resp = 2'b00;

    // Full FIFO blocks the 5th request; a response frees a slot for the next cycle
    p0_req = 1; p0_addr = 32'h600; m_req_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_ack", p0_req_ack, 1);
      tick();
    end
    #1;
    chk("t4_full_m_req", m_req, 0);
    chk("t4_full_ack", p0_req_ack, 0);
    chk("t4_full_addr", m_addr, 0);
    tick();
    m_resp = 2'b01; m_rdata = 32'hC0;
    #1;
    chk("t4_pop_m_req", m_req, 0);
    chk("t4_pop_resp", p0_resp, 2'b01);
    tick();
    m_resp = 2'b00;
    #1;
    chk("t4_refill_m_req", m_req, 1);
    chk("t4_refill_ack", p0_req_ack, 1);
    tick();
    p0_req = 0; m_req_ack = 0;
    for (int i = 0; i < 4; i++) begin
      m_resp = 2'b01; m_rdata = 32'hC1 + i;
      #1;
      chk("t4_drain_rdata", p0_rdata, 32'hC1 + i);
      tick();
    end
    m_resp = 2'b00;
    #1;
    chk("t4_idle", arb_idle, 1);
    chk("t4_err", err_unexp, 0);

    // Error response to p1, then an unexpected response with the FIFO empty
    p1_req = 1; p1_addr = 32'h700; m_req_ack = 1;
    #1;
    chk("t5_p1_ack", p1_req_ack, 1);
    tick();
    p1_req = 0; m_req_ack = 0; m_resp = 2'b10; m_rdata = 32'hBAD;
    #1;
    chk("t5_p1_resp", p1_resp, 2'b10);
    chk("t5_p1_rdata", p1_rdata, 32'hBAD);
    chk("t5_p0_resp", p0_resp, 2'b00);
    chk("t5_p0_rdata", p0_rdata, 0);
    tick();
    m_resp = 2'b01; m_rdata = 32'h99;
    #1;
    chk("t5_drop_p0", p0_resp, 2'b00);
    chk("t5_drop_p1", p1_resp, 2'b00);
    chk("t5_err_before", err_unexp, 0);
    tick();
    m_resp = 2'b00;
    #1;
    chk("t5_err_set", err_unexp, 1);
    tick();
    chk("t5_err_sticky", err_unexp, 1);

    // Reset with two outstanding requests
    p0_req = 1; p0_addr = 32'h800; m_req_ack = 1;
    tick();
    tick();
    p0_req = 0; m_req_ack = 0;
    #1;
    chk("t6_busy", arb_idle, 0);
    do_reset();
    chk("t6_idle", arb_idle, 1);
    chk("t6_err", err_unexp, 0);
    p0_req = 1; p0_addr = 32'h900; p1_req = 1; p1_addr = 32'hA00; m_req_ack = 1;
    #1;
    chk("t6_p0_first", p0_req_ack, 1);
    chk("t6_p1_wait", p1_req_ack, 0);
    tick();
    #1;
    chk("t6_p1_second", p1_req_ack, 1);
    tick();
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
